// File: rtl/maria_arb_pkg.sv
// Shared types and constants for the Maria bus arbiter.
package maria_arb_pkg;

  typedef enum logic [2:0] {
    ARB_IDLE     = 3'd0,
    ARB_HALT_REQ = 3'd1,
    ARB_TURN_ON  = 3'd2,
    ARB_OWNED    = 3'd3,
    ARB_TURN_OFF = 3'd4
  } arb_state_t;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_DMA  = 2'd1,
    OWN_DBG  = 2'd2
  } arb_owner_t;

  localparam int unsigned GNT_DMA = 0;
  localparam int unsigned GNT_DBG = 1;

  // One-hot grant vector for a given owner.
  function automatic logic [1:0] owner_grant(input arb_owner_t owner);
    logic [1:0] g;
    g = 2'b00;
    case (owner)
      OWN_DMA: g[GNT_DMA] = 1'b1;
      OWN_DBG: g[GNT_DBG] = 1'b1;
      default: g = 2'b00;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/sat_tick_counter.sv
// Saturating tick counter with clear; clear wins over a same-cycle increment.
module sat_tick_counter #(
  parameter int unsigned CNT_W = 13
) (
  input  logic             clk,
  input  logic             i_reset,
  input  logic             i_en,
  input  logic             i_clr,
  output logic [CNT_W-1:0] o_count
);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk) begin
    if (i_reset || i_clr) begin
      r_count <= '0;
    end else if (i_en && (r_count != '1)) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/maria_bus_arbiter.sv
// Arbitrates the 7800 AB/DB between the 6502, Maria DMA and the debug port,
// sequencing halt, turnaround, grant and release; keeps per-line tick counts.
module maria_bus_arbiter
  import maria_arb_pkg::*;
#(
  parameter int unsigned TURN_ON_MCLK  = 2,
  parameter int unsigned TURN_OFF_MCLK = 1,
  parameter int unsigned WAIT_LIMIT    = 8,
  parameter int unsigned CNT_W         = 13
) (
  input  logic             clk_sys,
  input  logic             reset,
  input  logic             mclk0,
  input  logic             pclk1,
  input  logic             cpu_rw,
  input  logic             lrc,
  input  logic             dma_req,
  input  logic             dma_done,
  input  logic             dbg_req,
  input  logic             dbg_done,
  output logic             halt_en,
  output logic             drive_AB,
  output logic [1:0]       grant,
  output logic             wait_timeout,
  output logic [CNT_W-1:0] halted_ticks,
  output logic [CNT_W-1:0] driven_ticks
);

  localparam int unsigned WAIT_W   = $clog2(WAIT_LIMIT + 1);
  localparam int unsigned TURN_MAX = (TURN_ON_MCLK > TURN_OFF_MCLK) ? TURN_ON_MCLK : TURN_OFF_MCLK;
  localparam int unsigned TURN_W   = (TURN_MAX > 1) ? $clog2(TURN_MAX) : 1;

  arb_state_t        r_state, w_state_nxt;
  arb_owner_t        r_owner, w_owner_nxt;
  logic [WAIT_W-1:0] r_wait_cnt, w_wait_nxt;
  logic [TURN_W-1:0] r_turn_cnt, w_turn_nxt;
  logic              r_halt_en, w_halt_nxt;
  logic              r_drive, w_drive_nxt;
  logic [1:0]        r_grant, w_grant_nxt;
  logic              r_timeout, w_timeout_nxt;
  logic              w_owner_req;
  logic              w_owner_done;

  assign w_owner_req  = (r_owner == OWN_DMA) ? dma_req  : (r_owner == OWN_DBG) ? dbg_req  : 1'b0;
  assign w_owner_done = (r_owner == OWN_DMA) ? dma_done : (r_owner == OWN_DBG) ? dbg_done : 1'b0;

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_state    <= ARB_IDLE;
      r_owner    <= OWN_NONE;
      r_wait_cnt <= '0;
      r_turn_cnt <= '0;
      r_halt_en  <= 1'b0;
      r_drive    <= 1'b0;
      r_grant    <= 2'b00;
      r_timeout  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_owner    <= w_owner_nxt;
      r_wait_cnt <= w_wait_nxt;
      r_turn_cnt <= w_turn_nxt;
      r_halt_en  <= w_halt_nxt;
      r_drive    <= w_drive_nxt;
      r_grant    <= w_grant_nxt;
      r_timeout  <= w_timeout_nxt;
    end
  end

  // Next state and next registered outputs.
  always_comb begin
    w_state_nxt   = r_state;
    w_owner_nxt   = r_owner;
    w_wait_nxt    = r_wait_cnt;
    w_turn_nxt    = r_turn_cnt;
    w_halt_nxt    = r_halt_en;
    w_drive_nxt   = r_drive;
    w_grant_nxt   = r_grant;
    w_timeout_nxt = 1'b0;

    case (r_state)
      ARB_IDLE: begin
        if (dma_req || dbg_req) begin
          w_owner_nxt = dma_req ? OWN_DMA : OWN_DBG;
          w_state_nxt = ARB_HALT_REQ;
          w_halt_nxt  = 1'b1;
          w_wait_nxt  = '0;
        end
      end

      ARB_HALT_REQ: begin
        if (!w_owner_req) begin
          w_state_nxt = ARB_IDLE;
          w_owner_nxt = OWN_NONE;
          w_halt_nxt  = 1'b0;
        end else if (pclk1) begin
          // Writes cannot be stretched; a run of them eventually forces the grant.
          if (cpu_rw) begin
            w_state_nxt = ARB_TURN_ON;
            w_turn_nxt  = '0;
          end else if (r_wait_cnt == WAIT_W'(WAIT_LIMIT)) begin
            w_timeout_nxt = 1'b1;
            w_state_nxt   = ARB_TURN_ON;
            w_turn_nxt    = '0;
          end else begin
            w_wait_nxt = r_wait_cnt + WAIT_W'(1);
          end
        end
      end

      ARB_TURN_ON: begin
        if (mclk0) begin
          if (r_turn_cnt == TURN_W'(TURN_ON_MCLK - 1)) begin
            w_state_nxt = ARB_OWNED;
            w_drive_nxt = 1'b1;
            w_grant_nxt = owner_grant(r_owner);
          end else begin
            w_turn_nxt = r_turn_cnt + TURN_W'(1);
          end
        end
      end

      ARB_OWNED: begin
        if (w_owner_done) begin
          w_state_nxt = ARB_TURN_OFF;
          w_drive_nxt = 1'b0;
          w_grant_nxt = 2'b00;
          w_turn_nxt  = '0;
        end
      end

      ARB_TURN_OFF: begin
        if (mclk0) begin
          if (r_turn_cnt == TURN_W'(TURN_OFF_MCLK - 1)) begin
            // Back-to-back hand-over keeps the CPU halted.
            if (dma_req || dbg_req) begin
              w_owner_nxt = dma_req ? OWN_DMA : OWN_DBG;
              w_state_nxt = ARB_TURN_ON;
              w_turn_nxt  = '0;
            end else begin
              w_state_nxt = ARB_IDLE;
              w_owner_nxt = OWN_NONE;
              w_halt_nxt  = 1'b0;
            end
          end else begin
            w_turn_nxt = r_turn_cnt + TURN_W'(1);
          end
        end
      end

      default: begin
        w_state_nxt = ARB_IDLE;
        w_owner_nxt = OWN_NONE;
        w_halt_nxt  = 1'b0;
        w_drive_nxt = 1'b0;
        w_grant_nxt = 2'b00;
      end
    endcase
  end

  sat_tick_counter #(.CNT_W(CNT_W)) u_halted_cnt (
    .clk     (clk_sys),
    .i_reset (reset),
    .i_en    (mclk0 & r_halt_en),
    .i_clr   (lrc),
    .o_count (halted_ticks)
  );

  sat_tick_counter #(.CNT_W(CNT_W)) u_driven_cnt (
    .clk     (clk_sys),
    .i_reset (reset),
    .i_en    (mclk0 & r_drive),
    .i_clr   (lrc),
    .o_count (driven_ticks)
  );

  assign halt_en      = r_halt_en;
  assign drive_AB     = r_drive;
  assign grant        = r_grant;
  assign wait_timeout = r_timeout;

endmodule

// File: tb/tb_maria_bus_arbiter.sv
// Self-checking bench for maria_bus_arbiter: grant-sequence scoreboard plus timing checks.
module tb_maria_bus_arbiter;

  logic        clk_sys, reset, mclk0, pclk1, cpu_rw, lrc;
  logic        dma_req, dma_done, dbg_req, dbg_done;
  logic        halt_en, drive_AB, wait_timeout;
  logic [1:0]  grant;
  logic [12:0] halted_ticks, driven_ticks;
  logic        w2_halt_en, w2_drive_AB, w2_wait_timeout;
  logic [1:0]  w2_grant;
  logic [12:0] w2_halted_ticks, w2_driven_ticks;

  int n_checks = 0;
  int n_fail   = 0;
  int to_main  = 0;
  int to_w2    = 0;
  logic [1:0] exp_q[$];
  logic       mon_en = 1'b0;

  maria_bus_arbiter u_dut (
    .clk_sys(clk_sys), .reset(reset), .mclk0(mclk0), .pclk1(pclk1), .cpu_rw(cpu_rw),
    .lrc(lrc), .dma_req(dma_req), .dma_done(dma_done), .dbg_req(dbg_req), .dbg_done(dbg_done),
    .halt_en(halt_en), .drive_AB(drive_AB), .grant(grant), .wait_timeout(wait_timeout),
    .halted_ticks(halted_ticks), .driven_ticks(driven_ticks)
  );

  maria_bus_arbiter #(.WAIT_LIMIT(2)) u_dut_w2 (
    .clk_sys(clk_sys), .reset(reset), .mclk0(mclk0), .pclk1(pclk1), .cpu_rw(cpu_rw),
    .lrc(lrc), .dma_req(dma_req), .dma_done(dma_done), .dbg_req(dbg_req), .dbg_done(dbg_done),
    .halt_en(w2_halt_en), .drive_AB(w2_drive_AB), .grant(w2_grant), .wait_timeout(w2_wait_timeout),
    .halted_ticks(w2_halted_ticks), .driven_ticks(w2_driven_ticks)
  );

  initial clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  // mclk0 every other clock, pclk1 once every 6 clocks; updated just after posedge.
  initial begin
    int pcnt;
    pcnt  = 0;
    mclk0 = 1'b0;
    pclk1 = 1'b0;
    forever begin
      @(posedge clk_sys);
      #2;
      mclk0 = ~mclk0;
      pclk1 = (pcnt == 5);
      pcnt  = (pcnt == 5) ? 0 : pcnt + 1;
    end
  end

  task automatic chk_eq(input string tag, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Scoreboard: every grant change must match the next queued expectation.
  initial begin
    logic [1:0] prev;
    logic [1:0] e;
    prev = 2'b00;
    forever begin
      @(negedge clk_sys);
      if (mon_en) begin
        if (wait_timeout) to_main++;
        if (w2_wait_timeout) to_w2++;
        if (grant !== prev) begin
          if (exp_q.size() == 0) begin
            chk_eq("grant_unexpected", int'(grant), int'(prev));
          end else begin
            e = exp_q.pop_front();
            chk_eq("grant_seq", int'(grant), int'(e));
          end
          prev = grant;
        end
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic wait_pclk1();
    int n;
    n = 0;
    while (!pclk1 && n < 20) begin
      @(negedge clk_sys);
      n++;
    end
    if (!pclk1) chk_eq("pclk1_wait", 0, 1);
  endtask

  task automatic next_pclk1();
    @(negedge clk_sys);
    wait_pclk1();
  endtask

  // Steps negedges until n mclk0 strobes have been consumed by posedges.
  task automatic pass_strobes(input int n);
    int c;
    c = 0;
    while (c < n) begin
      if (mclk0) c++;
      @(negedge clk_sys);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    dma_req = 1'b0; dbg_req = 1'b0; dma_done = 1'b0; dbg_done = 1'b0; lrc = 1'b0;
    repeat (3) @(negedge clk_sys);
    reset = 1'b0;
  endtask

  initial begin
    int n;
    int base;
    cpu_rw = 1'b1;
    do_reset();

    // 1: reset state
    chk_eq("rst_halt", int'(halt_en), 0);
    chk_eq("rst_drive", int'(drive_AB), 0);
    chk_eq("rst_grant", int'(grant), 0);
    chk_eq("rst_timeout", int'(wait_timeout), 0);
    chk_eq("rst_halted", int'(halted_ticks), 0);
    chk_eq("rst_driven", int'(driven_ticks), 0);
    chk_eq("rst_w2_ticks", int'(w2_halted_ticks) + int'(w2_driven_ticks), 0);
    mon_en = 1'b1;

    // 2: basic DMA grant and release
    cpu_rw = 1'b1;
    wait_pclk1();
    @(negedge clk_sys);
    dma_req = 1'b1;
    exp_q.push_back(2'b01);
    @(negedge clk_sys);
    chk_eq("dma_halt_rise", int'(halt_en), 1);
    chk_eq("dma_grant_pre", int'(grant), 0);
    wait_pclk1();
    @(negedge clk_sys);
    pass_strobes(1);
    chk_eq("dma_grant_early", int'(grant), 0);
    pass_strobes(1);
    chk_eq("dma_grant", int'(grant), 1);
    chk_eq("dma_drive", int'(drive_AB), 1);
    dma_req = 1'b0;
    repeat (3) @(negedge clk_sys);
    exp_q.push_back(2'b00);
    dma_done = 1'b1;
    @(negedge clk_sys);
    dma_done = 1'b0;
    chk_eq("dma_rel_drive", int'(drive_AB), 0);
    chk_eq("dma_rel_halt", int'(halt_en), 1);
    pass_strobes(1);
    chk_eq("dma_halt_drop", int'(halt_en), 0);

    // 3a: write cycles stall the grant until a read cycle ends
    cpu_rw = 1'b0;
    wait_pclk1();
    @(negedge clk_sys);
    dma_req = 1'b1;
    exp_q.push_back(2'b01);
    for (int k = 0; k < 3; k++) next_pclk1();
    @(negedge clk_sys);
    cpu_rw = 1'b1;
    chk_eq("wr_stall_grant", int'(grant), 0);
    wait_pclk1();
    chk_eq("wr_4th_grant", int'(grant), 0);
    @(negedge clk_sys);
    pass_strobes(2);
    chk_eq("wr_grant", int'(grant), 1);
    chk_eq("wr_no_timeout", to_main, 0);
    dma_req = 1'b0;
    exp_q.push_back(2'b00);
    dma_done = 1'b1;
    @(negedge clk_sys);
    dma_done = 1'b0;
    pass_strobes(1);

    // 3b: WAIT_LIMIT=2 instance forces a grant under continuous writes
    do_reset();
    cpu_rw = 1'b0;
    wait_pclk1();
    @(negedge clk_sys);
    dma_req = 1'b1;
    base = to_w2;
    next_pclk1();
    next_pclk1();
    @(negedge clk_sys);
    chk_eq("to_not_yet", int'(w2_wait_timeout), 0);
    wait_pclk1();
    @(negedge clk_sys);
    chk_eq("to_pulse", int'(w2_wait_timeout), 1);
    pass_strobes(2);
    chk_eq("to_pulse_end", int'(w2_wait_timeout), 0);
    chk_eq("to_grant", int'(w2_grant), 1);
    chk_eq("to_drive", int'(w2_drive_AB), 1);
    chk_eq("to_halt", int'(w2_halt_en), 1);
    chk_eq("to_count", to_w2 - base, 1);
    chk_eq("to_main_wait", int'(grant), 0);
    do_reset();

    // 4: simultaneous requests, DMA first, back-to-back to DBG
    cpu_rw = 1'b1;
    wait_pclk1();
    @(negedge clk_sys);
    dma_req = 1'b1;
    dbg_req = 1'b1;
    exp_q.push_back(2'b01);
    exp_q.push_back(2'b00);
    exp_q.push_back(2'b10);
    exp_q.push_back(2'b00);
    next_pclk1();
    @(negedge clk_sys);
    pass_strobes(2);
    chk_eq("prio_grant", int'(grant), 1);
    dma_req = 1'b0;
    dma_done = 1'b1;
    @(negedge clk_sys);
    dma_done = 1'b0;
    chk_eq("b2b_gap_grant", int'(grant), 0);
    chk_eq("b2b_gap_halt", int'(halt_en), 1);
    pass_strobes(1);
    chk_eq("b2b_turnon_halt", int'(halt_en), 1);
    pass_strobes(2);
    chk_eq("b2b_dbg_grant", int'(grant), 2);
    chk_eq("b2b_dbg_halt", int'(halt_en), 1);
    dbg_req = 1'b0;
    dbg_done = 1'b1;
    @(negedge clk_sys);
    dbg_done = 1'b0;
    pass_strobes(1);
    chk_eq("b2b_halt_drop", int'(halt_en), 0);

    // 5: abort in HALT_REQ, then foreign done ignored
    cpu_rw = 1'b0;
    @(negedge clk_sys);
    dbg_req = 1'b1;
    @(negedge clk_sys);
    chk_eq("abort_halt_on", int'(halt_en), 1);
    dbg_req = 1'b0;
    @(negedge clk_sys);
    chk_eq("abort_halt_off", int'(halt_en), 0);
    cpu_rw = 1'b1;
    wait_pclk1();
    @(negedge clk_sys);
    dma_req = 1'b1;
    exp_q.push_back(2'b01);
    next_pclk1();
    @(negedge clk_sys);
    pass_strobes(2);
    dma_req = 1'b0;
    dbg_done = 1'b1;
    @(negedge clk_sys);
    dbg_done = 1'b0;
    chk_eq("ignore_grant", int'(grant), 1);
    repeat (4) @(negedge clk_sys);
    chk_eq("ignore_drive", int'(drive_AB), 1);
    exp_q.push_back(2'b00);
    dma_done = 1'b1;
    @(negedge clk_sys);
    dma_done = 1'b0;
    pass_strobes(1);

    // 6: saturation, lrc clear, reset while owned
    lrc = 1'b1;
    @(negedge clk_sys);
    lrc = 1'b0;
    chk_eq("lrc_halted", int'(halted_ticks), 0);
    chk_eq("lrc_driven", int'(driven_ticks), 0);
    wait_pclk1();
    @(negedge clk_sys);
    dma_req = 1'b1;
    exp_q.push_back(2'b01);
    next_pclk1();
    @(negedge clk_sys);
    pass_strobes(2);
    dma_req = 1'b0;
    n = 0;
    while (halted_ticks != 13'd8190 && n < 20000) begin
      @(negedge clk_sys);
      n++;
    end
    chk_eq("sat_preload", int'(halted_ticks), 8190);
    pass_strobes(4);
    chk_eq("sat_halted", int'(halted_ticks), 8191);
    pass_strobes(8);
    chk_eq("sat_hold", int'(halted_ticks), 8191);
    chk_eq("sat_driven", int'(driven_ticks), 8191);
    while (!mclk0) @(negedge clk_sys);
    lrc = 1'b1;
    @(negedge clk_sys);
    lrc = 1'b0;
    chk_eq("lrc_strobe_halted", int'(halted_ticks), 0);
    chk_eq("lrc_strobe_driven", int'(driven_ticks), 0);
    pass_strobes(1);
    chk_eq("post_lrc_count", int'(halted_ticks), 1);
    exp_q.push_back(2'b00);
    reset = 1'b1;
    @(negedge clk_sys);
    reset = 1'b0;
    chk_eq("rst_owned_drive", int'(drive_AB), 0);
    chk_eq("rst_owned_halt", int'(halt_en), 0);
    chk_eq("rst_owned_grant", int'(grant), 0);
    repeat (2) @(negedge clk_sys);
    chk_eq("sb_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
